spi_slave_rx_param: RTL and testbench

- Parametrised SPI slave receiver, next generation of the fixed 12-bit slave.
- Samples MOSI on the shared synchronous SPI clock while CS is low and assembles DATA_W-bit words with a selectable bit order.
- Supports continuous multi-word frames and partial-frame abort detection.
- Delivers words through a valid/ready holding register with a sticky overrun flag; sits between the SPI master model and the consuming logic/scoreboard.

---
 rtl/spi_slave_rx_param.sv | 151 +++++++++++++++
 tb/tb_spi_slave_rx_param.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_param.sv
// Parametrised SPI slave receiver that assembles DATA_W-bit words into a valid/ready holding register.
// Define SPI_SLAVE_TX_EN to add the full-duplex transmit path (tx_data in, miso out).
module spi_slave_rx_param #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned CONT_MODE = 0
) (
  input  logic              sync_clock,
  input  logic              rst,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              done,
  output logic              frame_err,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef SPI_SLAVE_TX_EN
  ,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso
`endif
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StWaitHi} state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ferr, w_ferr_nxt;
  logic              r_ovr, w_ovr_nxt;
  logic              w_sample, w_complete;

  assign w_sample   = (r_state == StShift) && !cs;
  assign w_complete = w_sample && (r_cnt == LastCnt);
  assign w_shift_in = (LSB_FIRST != 0) ? {mosi, r_shift[DATA_W-1:1]}
                                       : {r_shift[DATA_W-2:0], mosi};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;

    unique case (r_state)
      StIdle: begin
        if (!cs) begin
          w_state_nxt = StShift;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      StShift: begin
        if (cs) begin
          w_ferr_nxt  = (r_cnt != '0);
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end else if (w_complete) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_state_nxt = (CONT_MODE != 0) ? StShift : StWaitHi;
        end else begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      StWaitHi: begin
        if (cs) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    // A fresh overrun on the same edge as ovr_clr must win, so the set is applied last.
    if (ovr_clr) w_ovr_nxt = 1'b0;
    if (w_complete) begin
      if (!r_valid || rx_ready) begin
        w_dout_nxt  = w_shift_in;
        w_valid_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end else if (r_valid && rx_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge sync_clock) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign dout      = r_dout;
  assign rx_valid  = r_valid;
  assign done      = r_done;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

`ifdef SPI_SLAVE_TX_EN
  logic [DATA_W-1:0] r_tx, w_tx_nxt;

  // Reload at frame start and at every word boundary that keeps shifting.
  always_comb begin
    w_tx_nxt = r_tx;
    if ((r_state == StIdle) && !cs) begin
      w_tx_nxt = tx_data;
    end else if (w_complete && (CONT_MODE != 0)) begin
      w_tx_nxt = tx_data;
    end else if (w_sample) begin
      w_tx_nxt = (LSB_FIRST != 0) ? (r_tx >> 1) : (r_tx << 1);
    end
  end

  always_ff @(posedge sync_clock) begin
    if (rst) r_tx <= '0;
    else     r_tx <= w_tx_nxt;
  end

  assign miso = (r_state == StShift) && ((LSB_FIRST != 0) ? r_tx[0] : r_tx[DATA_W-1]);
`endif

endmodule

// File: tb/tb_spi_slave_rx_param.sv
// Bench for spi_slave_rx_param: three configurations share one stimulus stream and are checked
// every cycle against a bit-collecting reference model, plus directed frames and corner sequences.
module tb_spi_slave_rx_param;

  localparam int NI = 3;
  localparam int W0 = 12;
  localparam int W1 = 8;
  localparam int W2 = 8;

  logic          clk = 1'b0;
  logic          rst, cs, mosi, rx_ready, ovr_clr;
  logic [31:0]   tx_data;
  logic [W0-1:0] dout0;
  logic [W1-1:0] dout1;
  logic [W2-1:0] dout2;
  logic [NI-1:0] valid, done, ferr, ovr, miso;
  logic [31:0]   a_dout [NI];

  always #5 clk = ~clk;

  spi_slave_rx_param #(.DATA_W(W0), .LSB_FIRST(1), .CONT_MODE(0)) u_dut0 (
    .sync_clock(clk), .rst(rst), .cs(cs), .mosi(mosi), .dout(dout0), .rx_valid(valid[0]),
    .rx_ready(rx_ready), .done(done[0]), .frame_err(ferr[0]), .overrun(ovr[0]),
    .ovr_clr(ovr_clr)
`ifdef SPI_SLAVE_TX_EN
    , .tx_data(tx_data[W0-1:0]), .miso(miso[0])
`endif
  );

  spi_slave_rx_param #(.DATA_W(W1), .LSB_FIRST(0), .CONT_MODE(0)) u_dut1 (
    .sync_clock(clk), .rst(rst), .cs(cs), .mosi(mosi), .dout(dout1), .rx_valid(valid[1]),
    .rx_ready(rx_ready), .done(done[1]), .frame_err(ferr[1]), .overrun(ovr[1]),
    .ovr_clr(ovr_clr)
`ifdef SPI_SLAVE_TX_EN
    , .tx_data(tx_data[W1-1:0]), .miso(miso[1])
`endif
  );

  spi_slave_rx_param #(.DATA_W(W2), .LSB_FIRST(1), .CONT_MODE(1)) u_dut2 (
    .sync_clock(clk), .rst(rst), .cs(cs), .mosi(mosi), .dout(dout2), .rx_valid(valid[2]),
    .rx_ready(rx_ready), .done(done[2]), .frame_err(ferr[2]), .overrun(ovr[2]),
    .ovr_clr(ovr_clr)
`ifdef SPI_SLAVE_TX_EN
    , .tx_data(tx_data[W2-1:0]), .miso(miso[2])
`endif
  );

`ifndef SPI_SLAVE_TX_EN
  assign miso = '0;
`endif

  assign a_dout[0] = 32'(dout0);
  assign a_dout[1] = 32'(dout1);
  assign a_dout[2] = 32'(dout2);

  // Reference model: per-instance bit list, word assembled only when the list is full.
  int          mw    [NI] = '{W0, W1, W2};
  bit          mlsb  [NI] = '{1'b1, 1'b0, 1'b1};
  bit          mcont [NI] = '{1'b0, 1'b0, 1'b1};
  bit          act   [NI];
  bit          waith [NI];
  int          mcnt  [NI];
  bit          mb    [NI][32];
  logic [31:0] mtx   [NI];
  int          mtxi  [NI];
  logic [31:0] e_dout [NI];
  bit          e_valid [NI], e_done [NI], e_ferr [NI], e_ovr [NI], e_miso [NI];

  int n_vec = 0;
  int n_err = 0;

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      logic [31:0] word;
      bit fin, oset;
      word = '0; fin = 1'b0; oset = 1'b0;
      e_done[k] = 1'b0;
      e_ferr[k] = 1'b0;
      if (rst) begin
        act[k] = 0; waith[k] = 0; mcnt[k] = 0; e_dout[k] = '0;
        e_valid[k] = 0; e_ovr[k] = 0; e_miso[k] = 0;
        continue;
      end
      if (cs) begin
        if (act[k] && mcnt[k] > 0) e_ferr[k] = 1'b1;
        act[k] = 0; waith[k] = 0; mcnt[k] = 0;
      end else if (waith[k]) begin
        // waiting for cs to rise
      end else if (!act[k]) begin
        act[k] = 1; mcnt[k] = 0; mtx[k] = tx_data; mtxi[k] = 0;
      end else begin
        mb[k][mcnt[k]] = mosi;
        mcnt[k]++;
        mtxi[k]++;
        if (mcnt[k] == mw[k]) begin
          for (int i = 0; i < mw[k]; i++) begin
            if (mlsb[k]) word[i] = mb[k][i];
            else         word[mw[k]-1-i] = mb[k][i];
          end
          fin = 1'b1;
          mcnt[k] = 0;
          if (mcont[k]) begin
            mtx[k] = tx_data; mtxi[k] = 0;
          end else begin
            waith[k] = 1;
          end
        end
      end
      e_done[k] = fin;
      if (fin) begin
        if (!e_valid[k] || rx_ready) begin
          e_dout[k] = word; e_valid[k] = 1;
        end else begin
          oset = 1'b1;
        end
      end else if (e_valid[k] && rx_ready) begin
        e_valid[k] = 0;
      end
      if (ovr_clr) e_ovr[k] = 0;
      if (oset)    e_ovr[k] = 1;
      if (act[k] && !waith[k])
        e_miso[k] = mtx[k][mlsb[k] ? mtxi[k] : mw[k]-1-mtxi[k]];
      else
        e_miso[k] = 0;
    end
  endtask

  task automatic cmp(string name, int k, logic [31:0] act_v, logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act_v, exp_v, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      cmp("dout", k, a_dout[k], e_dout[k]);
      cmp("rx_valid", k, 32'(valid[k]), 32'(e_valid[k]));
      cmp("done", k, 32'(done[k]), 32'(e_done[k]));
      cmp("frame_err", k, 32'(ferr[k]), 32'(e_ferr[k]));
      cmp("overrun", k, 32'(ovr[k]), 32'(e_ovr[k]));
`ifdef SPI_SLAVE_TX_EN
      cmp("miso", k, 32'(miso[k]), 32'(e_miso[k]));
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; cs = 1; mosi = 0; rx_ready = 0; ovr_clr = 0;
    tick();
    rst = 0;
    cmp("reset_dout", 0, a_dout[0], 32'h0);
    cmp("reset_valid", 0, 32'(valid[0]), 32'h0);
    cmp("reset_ovr", 0, 32'(ovr[0]), 32'h0);
  endtask

  // Starts from IDLE: one start edge, then n bits in instance k's bit order.
  task automatic send(int k, logic [31:0] w, int n, bit rdy_last);
    cs = 0; mosi = 0;
    tick();
    for (int i = 0; i < n; i++) begin
      mosi     = mlsb[k] ? w[i] : w[mw[k]-1-i];
      rx_ready = (i == n - 1) ? rdy_last : 1'b0;
      tick();
      cmp("done_timing", k, 32'(done[k]), 32'(i == mw[k] - 1));
    end
    rx_ready = 0;
  endtask

  task automatic raise();
    cs = 1;
    tick();
  endtask

  typedef struct {
    int          k;
    logic [31:0] word;
    int          nbits;
    logic [31:0] exp_dout;
    bit          exp_valid;
    bit          exp_ferr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [31:0] w;
    logic [11:0] seq;
    rst = 1; cs = 1; mosi = 0; rx_ready = 0; ovr_clr = 0; tx_data = '0;

    tbl[0] = '{0, 32'hA5C, 12, 32'hA5C, 1'b1, 1'b0};
    tbl[1] = '{1, 32'h03C,  8, 32'h03C, 1'b1, 1'b0};
    tbl[2] = '{0, 32'h01F,  5, 32'h000, 1'b0, 1'b1};
    tbl[3] = '{2, 32'h096,  8, 32'h096, 1'b1, 1'b0};
    tbl[4] = '{1, 32'h081,  8, 32'h081, 1'b1, 1'b0};

    for (int t = 0; t < 5; t++) begin
      do_reset();
      send(tbl[t].k, tbl[t].word, tbl[t].nbits, 1'b0);
      cmp("tbl_dout", tbl[t].k, a_dout[tbl[t].k], tbl[t].exp_dout);
      cmp("tbl_valid", tbl[t].k, 32'(valid[tbl[t].k]), 32'(tbl[t].exp_valid));
      raise();
      cmp("tbl_ferr", tbl[t].k, 32'(ferr[tbl[t].k]), 32'(tbl[t].exp_ferr));
    end

    // rx_ready for one cycle consumes the held word.
    do_reset();
    send(1, 32'h3C, 8, 1'b0);
    raise();
    rx_ready = 1;
    tick();
    rx_ready = 0;
    cmp("ready_clears_valid", 1, 32'(valid[1]), 32'h0);

    // Abort keeps the held word; a later full frame replaces it.
    do_reset();
    send(0, 32'hA5C, 12, 1'b0);
    raise();
    send(0, 32'h01F, 5, 1'b0);
    raise();
    cmp("abort_ferr", 0, 32'(ferr[0]), 32'h1);
    cmp("abort_dout", 0, a_dout[0], 32'hA5C);
    cmp("abort_valid", 0, 32'(valid[0]), 32'h1);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    cmp("abort_ferr_pulse", 0, 32'(ferr[0]), 32'h0);
    send(0, 32'h123, 12, 1'b0);
    cmp("after_abort_dout", 0, a_dout[0], 32'h123);
    raise();

    // Continuous mode: two words with no consumer, second one overruns.
    do_reset();
    cs = 0;
    tick();
    w = 32'h2211;
    for (int i = 0; i < 16; i++) begin
      mosi = w[i];
      tick();
      cmp("cont_done", 2, 32'(done[2]), 32'(i == 7 || i == 15));
    end
    cmp("cont_dout", 2, a_dout[2], 32'h11);
    cmp("cont_ovr", 2, 32'(ovr[2]), 32'h1);
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
    cmp("ovr_clr", 2, 32'(ovr[2]), 32'h0);
    raise();

    // Completion and rx_ready on the same edge.
    do_reset();
    send(0, 32'hA5C, 12, 1'b0);
    raise();
    send(0, 32'h3B7, 12, 1'b1);
    cmp("same_edge_dout", 0, a_dout[0], 32'h3B7);
    cmp("same_edge_valid", 0, 32'(valid[0]), 32'h1);
    cmp("same_edge_ovr", 0, 32'(ovr[0]), 32'h0);
    raise();

`ifdef SPI_SLAVE_TX_EN
    // Reset mid-frame, then a full-duplex frame.
    do_reset();
    tx_data = 32'h5A3;
    cs = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    cmp("tx_reset_dout", 0, a_dout[0], 32'h0);
    cmp("tx_reset_miso", 0, 32'(miso[0]), 32'h0);
    tick();
    seq = 12'h5A3;
    for (int i = 0; i < 12; i++) begin
      cmp("tx_miso_seq", 0, 32'(miso[0]), 32'(seq[i]));
      mosi = seq[i];
      tick();
    end
    cmp("tx_dout", 0, a_dout[0], 32'h5A3);
    raise();
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 249) == 0);
      cs       = ($urandom_range(0, 99) < (cs ? 70 : 4));
      mosi     = 1'($urandom);
      rx_ready = ($urandom_range(0, 3) == 0);
      ovr_clr  = ($urandom_range(0, 15) == 0);
      tx_data  = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
